// File: rtl/wb_select_unit_pkg.sv
// Shared encodings for the write-back selector: load-size modes, FSM states and
// the default value of the constant source channel.
package wb_select_unit_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int unsigned WbConstValDefault = 227;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_size_extract.sv
// Load-size extraction: picks a half or byte lane out of a 32-bit word and
// sign- or zero-extends it. Word mode passes the value through untouched.
module wb_size_extract
  import wb_select_unit_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [15:0] half_val;
  logic [7:0]  byte_val;

  assign half_val = off_i[1] ? data_i[31:16] : data_i[15:0];
  assign byte_val = data_i[{off_i, 3'b000} +: 8];

  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_HALF: data_o = {{16{sext_i & half_val[15]}}, half_val};
      SZ_BYTE: data_o = {{24{sext_i & byte_val[7]}}, byte_val};
      SZ_WORD: data_o = data_i;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_select_unit.sv
// Registered write-back source selector: picks one of NUM_SRC channels, waits out
// the memory latency when needed, applies load-size extraction and strobes wb_valid.
module wb_select_unit
  import wb_select_unit_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_SRC   = 9,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned MEM_SRC   = 1,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned CONST_SRC = 2,
  parameter int unsigned CONST_VAL = WbConstValDefault
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SEL_W-1:0]          sel,
  input  logic [1:0]                size_mode,
  input  logic                      sign_ext,
  input  logic [1:0]                byte_off,
  input  logic [NUM_SRC*DATA_W-1:0] src_bus,
  input  logic                      stall,
  output logic                      busy,
  output logic                      wb_valid,
  output logic [DATA_W-1:0]         wb_data,
  output logic                      sel_err
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  wb_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [1:0]        off_q, off_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              in_wait, accept, sel_is_mem, sel_bad;
  logic [SEL_W-1:0]  sel_eff;
  logic [1:0]        size_eff, off_eff;
  logic              sext_eff;
  logic [DATA_W-1:0] src_val, ext_val;

  assign in_wait    = (state_q == StWait);
  assign busy       = in_wait || ((state_q == StDone) && stall);
  assign accept     = start && !busy;
  assign sel_is_mem = (sel == SEL_W'(MEM_SRC));
  assign sel_bad    = (32'(sel) >= NUM_SRC);

  // A finishing memory wait uses the latched request; otherwise the live one.
  assign sel_eff  = in_wait ? sel_q  : sel;
  assign size_eff = in_wait ? size_q : size_mode;
  assign sext_eff = in_wait ? sext_q : sign_ext;
  assign off_eff  = in_wait ? off_q  : byte_off;

  always_comb begin
    src_val = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (32'(sel_eff) == k) begin
        src_val = (k == CONST_SRC) ? DATA_W'(CONST_VAL) : src_bus[k*DATA_W +: DATA_W];
      end
    end
  end

  wb_size_extract u_extract (
    .data_i (src_val),
    .size_i (size_eff),
    .sext_i (sext_eff),
    .off_i  (off_eff),
    .data_o (ext_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    valid_d = valid_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          valid_d = 1'b1;
          data_d  = ext_val;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        if (accept) begin
          sel_d  = sel;
          size_d = size_mode;
          sext_d = sign_ext;
          off_d  = byte_off;
          if (sel_is_mem && (MEM_LAT > 0)) begin
            state_d = StWait;
            cnt_d   = CntW'(MEM_LAT - 1);
            valid_d = 1'b0;
          end else begin
            state_d = StDone;
            valid_d = 1'b1;
            data_d  = ext_val;
            err_d   = sel_bad;
          end
        end else if (!busy) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      off_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign wb_valid = valid_q;
  assign wb_data  = data_q;
  assign sel_err  = err_q;

endmodule
